// File: rtl/output_buffer_ctrl_pkg.sv
// Shared types and defaults for the output buffer controller.
// Holds the phase encoding and default frame geometry.
package output_buffer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_WRITE = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_OUT_CHANNELS = 3;
  localparam int DEF_IN_WIDTH     = 5;
  localparam int DEF_IN_HEIGHT    = 5;

  localparam int PIX    = DEF_IN_WIDTH * DEF_IN_HEIGHT;
  localparam int ADDR_W = $clog2(PIX * DEF_OUT_CHANNELS);

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/output_buffer_ctrl_fifo.sv
// Two-entry skid FIFO between the buffer read port and the output stream.
// Payload is {last, data}; head is held until popped.
module skid_fifo2
  import output_buffer_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign valid = (cnt != 2'd0);
  assign head  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/output_buffer_ctrl.sv
// Output buffer sequencer: scatters interleaved results into planar
// order, then streams the frame back out through a skid FIFO.
module output_buffer_ctrl
  import output_buffer_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int OUT_CHANNELS = DEF_OUT_CHANNELS,
  parameter int IN_WIDTH     = DEF_IN_WIDTH,
  parameter int IN_HEIGHT    = DEF_IN_HEIGHT,
  parameter int DEPTH        = IN_WIDTH * IN_HEIGHT * OUT_CHANNELS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_last,
  output logic                     frame_done,
  output logic                     busy,
  output logic                     buf_wr_en,
  output logic [$clog2(DEPTH)-1:0] buf_wr_addr,
  output logic [DATA_WIDTH-1:0]    buf_wr_data,
  output logic                     buf_rd_en,
  output logic [$clog2(DEPTH)-1:0] buf_rd_addr,
  input  logic [DATA_WIDTH-1:0]    buf_rd_data
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = cnt_w(OUT_CHANNELS);
  localparam int NPIX = IN_WIDTH * IN_HEIGHT;

  localparam logic [AW-1:0] PIX_STEP = AW'(NPIX);
  localparam logic [AW-1:0] PIX_LAST = AW'(NPIX - 1);
  localparam logic [AW-1:0] RD_LAST  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(OUT_CHANNELS - 1);

  state_t state, state_nx;

  logic [CW-1:0]   ch_cnt;
  logic [AW-1:0]   pix_cnt;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   rd_cnt;
  logic            inflight;
  logic            inflight_last;
  logic            wr_hs;
  logic            ch_wrap;
  logic            frame_end;
  logic            rd_last;
  logic            pop;
  logic [1:0]      fifo_count;
  logic [2:0]      occ;
  logic            fifo_valid;
  logic [DATA_WIDTH:0] fifo_head;

  assign in_ready    = (state == ST_WRITE);
  assign wr_hs       = in_valid & in_ready;
  assign ch_wrap     = (ch_cnt == CH_LAST);
  assign frame_end   = wr_hs & ch_wrap & (pix_cnt == PIX_LAST);
  assign buf_wr_en   = wr_hs;
  assign buf_wr_addr = wr_addr;
  assign buf_wr_data = in_data;

  assign out_valid = fifo_valid;
  assign out_data  = fifo_head[DATA_WIDTH-1:0];
  assign out_last  = fifo_head[DATA_WIDTH];
  assign pop       = out_valid & out_ready;

  // Occupancy after this cycle's pop; keeps the FIFO from overflowing.
  assign occ         = 3'(fifo_count) + 3'(inflight) - 3'(pop);
  assign buf_rd_en   = (state == ST_READ) && (occ < 3'd2);
  assign buf_rd_addr = rd_cnt;
  assign rd_last     = buf_rd_en && (rd_cnt == RD_LAST);

  assign frame_done = (state == ST_DRAIN) && pop && out_last;
  assign busy       = (state != ST_WRITE);

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_WRITE: if (frame_end) state_nx = ST_READ;
      ST_READ:  if (rd_last) state_nx = ST_DRAIN;
      ST_DRAIN: if (frame_done) state_nx = ST_WRITE;
      default:  state_nx = ST_WRITE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_WRITE;
      ch_cnt        <= '0;
      pix_cnt       <= '0;
      wr_addr       <= '0;
      rd_cnt        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state         <= state_nx;
      inflight      <= buf_rd_en;
      inflight_last <= rd_last;
      if (wr_hs) begin
        if (!ch_wrap) begin
          ch_cnt  <= ch_cnt + 1'b1;
          wr_addr <= wr_addr + PIX_STEP;
        end else if (pix_cnt == PIX_LAST) begin
          ch_cnt  <= '0;
          pix_cnt <= '0;
          wr_addr <= '0;
        end else begin
          ch_cnt  <= '0;
          pix_cnt <= pix_cnt + 1'b1;
          wr_addr <= pix_cnt + 1'b1;
        end
      end
      if (buf_rd_en) rd_cnt <= rd_last ? '0 : rd_cnt + 1'b1;
    end
  end

  skid_fifo2 #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_data({inflight_last, buf_rd_data}),
    .pop      (pop),
    .valid    (fifo_valid),
    .head     (fifo_head),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_output_buffer_ctrl.sv
// Bench for output_buffer_ctrl: a 2x2x2 instance driven from a vector
// table and a default 5x5x3 instance checked against a planar model.
module tb_output_buffer_ctrl;

  localparam int SA = 3;
  localparam int DA = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- small instance (W=2,H=2,C=2) ----------------
  logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [7:0]    s_in_data, s_out_data, s_wr_data, s_rd_data;
  logic          s_out_last, s_frame_done, s_busy, s_wr_en, s_rd_en;
  logic [SA-1:0] s_wr_addr, s_rd_addr;
  logic [7:0]    s_mem [8];

  output_buffer_ctrl #(
    .DATA_WIDTH(8), .OUT_CHANNELS(2), .IN_WIDTH(2), .IN_HEIGHT(2)
  ) u_s (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .out_last(s_out_last),
    .frame_done(s_frame_done), .busy(s_busy),
    .buf_wr_en(s_wr_en), .buf_wr_addr(s_wr_addr), .buf_wr_data(s_wr_data),
    .buf_rd_en(s_rd_en), .buf_rd_addr(s_rd_addr), .buf_rd_data(s_rd_data)
  );

  always @(posedge clk) begin
    if (s_wr_en) s_mem[s_wr_addr] <= s_wr_data;
    if (s_rd_en) s_rd_data <= s_mem[s_rd_addr];
  end

  // ---------------- default instance (5x5x3) ----------------
  logic          d_in_valid, d_in_ready, d_out_valid, d_out_ready;
  logic [7:0]    d_in_data, d_out_data, d_wr_data, d_rd_data;
  logic          d_out_last, d_frame_done, d_busy, d_wr_en, d_rd_en;
  logic [DA-1:0] d_wr_addr, d_rd_addr;
  logic [7:0]    d_mem [128];

  output_buffer_ctrl u_d (
    .clk(clk), .rst(rst),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
    .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_data(d_out_data), .out_last(d_out_last),
    .frame_done(d_frame_done), .busy(d_busy),
    .buf_wr_en(d_wr_en), .buf_wr_addr(d_wr_addr), .buf_wr_data(d_wr_data),
    .buf_rd_en(d_rd_en), .buf_rd_addr(d_rd_addr), .buf_rd_data(d_rd_data)
  );

  always @(posedge clk) begin
    if (d_wr_en) d_mem[d_wr_addr] <= d_wr_data;
    if (d_rd_en) d_rd_data <= d_mem[d_rd_addr];
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]    din;
    logic [SA-1:0] wa;
    logic [7:0]    dout;
    logic          last;
  } vec_t;
  vec_t vec [8];

  // ---------------- small monitor ----------------
  logic [8:0] s_q [$];
  int         s_hs_cyc [$];
  int         s_cyc = 0;
  int         s_issued = 0;
  int         s_popped = 0;
  int         s_fd = 0;
  bit         s_prev_fd = 0;
  bit         s_prev_stall = 0;
  logic [7:0] s_prev_data;

  always @(negedge clk) begin
    bit pop;
    s_cyc++;
    if (rst) begin
      s_issued = 0;
      s_popped = 0;
      s_prev_fd = 0;
      s_prev_stall = 0;
    end else begin
      pop = s_out_valid && s_out_ready;
      if (s_prev_fd) check("s_accept_after_done", 32'(s_in_ready), 1);
      if (s_prev_stall) check("s_stall_stable", 32'(s_out_data), 32'(s_prev_data));
      if (s_busy) check("s_no_write_busy", {s_in_ready, s_wr_en}, 0);
      if (s_rd_en) begin
        check("s_issue_rule", 32'((s_issued - s_popped - int'(pop)) < 2), 1);
        s_issued++;
      end
      if (pop) begin
        s_q.push_back({s_out_last, s_out_data});
        s_hs_cyc.push_back(s_cyc);
        s_popped++;
      end
      if (s_frame_done) begin
        s_fd++;
        check("s_done_on_last", 32'(pop && s_out_last), 1);
      end
      s_prev_fd = s_frame_done;
      s_prev_stall = s_out_valid && !s_out_ready;
      s_prev_data = s_out_data;
    end
  end

  // ---------------- default monitor ----------------
  logic [8:0] d_q [$];
  int         d_fd = 0;
  bit         d_prev_fd = 0;

  always @(negedge clk) begin
    if (rst) begin
      d_prev_fd = 0;
    end else begin
      if (d_prev_fd) check("d_accept_after_done", 32'(d_in_ready), 1);
      if (d_busy) check("d_in_ready_busy", 32'(d_in_ready), 0);
      if (d_out_valid && d_out_ready) d_q.push_back({d_out_last, d_out_data});
      if (d_frame_done) d_fd++;
      d_prev_fd = d_frame_done;
    end
  end

  // ---------------- small tasks ----------------
  task automatic s_write(input logic [7:0] base, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        s_in_valid = 1'b0;
        #1;
        check("s_gap_no_wr", 32'(s_wr_en), 0);
        @(posedge clk); #1;
      end
      s_in_valid = 1'b1;
      s_in_data  = base + vec[i].din;
      #1;
      check("s_wr_en", 32'(s_wr_en), 1);
      check("s_wr_addr", 32'(s_wr_addr), 32'(vec[i].wa));
      check("s_wr_data", 32'(s_wr_data), 32'(base + vec[i].din));
      @(posedge clk); #1;
    end
    s_in_valid = 1'b0;
  endtask

  task automatic s_read(input logic [7:0] base, input int mode,
                        input bit consec);
    int   fd0 = s_fd;
    bit   done = 0;
    logic [3:0] pat = 4'b1001;
    s_q.delete();
    s_hs_cyc.delete();
    s_in_valid = 1'b1;
    s_in_data  = 8'hEE;
    for (int t = 0; t < 200 && !done; t++) begin
      case (mode)
        0:       s_out_ready = 1'b1;
        1:       s_out_ready = pat[t % 4];
        default: s_out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (s_fd != fd0) begin
        done = 1;
        s_in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    s_out_ready = 1'b0;
    s_in_valid  = 1'b0;
    check("s_read_timeout", 32'(done), 1);
    check("s_out_count", 32'(s_q.size()), 8);
    for (int i = 0; i < 8 && i < s_q.size(); i++) begin
      check("s_out_data", 32'(s_q[i][7:0]), 32'(base + vec[i].dout));
      check("s_out_last", 32'(s_q[i][8]), 32'(vec[i].last));
    end
    check("s_frame_done_cnt", 32'(s_fd - fd0), 1);
    if (consec && s_hs_cyc.size() == 8)
      check("s_one_per_cycle", 32'(s_hs_cyc[7] - s_hs_cyc[0]), 7);
  endtask

  // ---------------- default-size frame with model ----------------
  task automatic d_frame();
    logic [7:0] src [75];
    logic [7:0] exp [75];
    int i = 0;
    int g = 0;
    int fd0;
    bit done = 0;
    for (int k = 0; k < 75; k++) src[k] = 8'($urandom);
    for (int c = 0; c < 3; c++)
      for (int p = 0; p < 25; p++)
        exp[c * 25 + p] = src[p * 3 + c];
    while (i < 75 && g < 1000) begin
      g++;
      d_in_valid = (i == 0) || ($urandom_range(0, 3) != 0);
      d_in_data  = src[i];
      @(negedge clk);
      if (d_in_valid && d_in_ready) i++;
      @(posedge clk); #1;
    end
    d_in_valid = 1'b0;
    check("d_write_count", 32'(i), 75);
    d_q.delete();
    fd0 = d_fd;
    for (int t = 0; t < 2000 && !done; t++) begin
      d_out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (d_fd != fd0) done = 1;
      @(posedge clk); #1;
    end
    d_out_ready = 1'b0;
    check("d_read_timeout", 32'(done), 1);
    check("d_out_count", 32'(d_q.size()), 75);
    for (int k = 0; k < 75 && k < d_q.size(); k++) begin
      check("d_out_data", 32'(d_q[k][7:0]), 32'(exp[k]));
      check("d_out_last", 32'(d_q[k][8]), 32'(k == 74));
    end
    check("d_frame_done_cnt", 32'(d_fd - fd0), 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [SA-1:0] wa_tab [8] = '{0, 4, 1, 5, 2, 6, 3, 7};
    logic [7:0]    do_tab [8] = '{0, 2, 4, 6, 1, 3, 5, 7};
    for (int i = 0; i < 8; i++) begin
      vec[i].din  = 8'(i);
      vec[i].wa   = wa_tab[i];
      vec[i].dout = do_tab[i];
      vec[i].last = (i == 7);
    end

    rst = 1'b1;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
    d_in_valid = 1'b0; d_in_data = '0; d_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(s_busy), 0);
    check("rst_out_valid", 32'(s_out_valid), 0);
    check("rst_in_ready", 32'(s_in_ready), 1);
    check("rst_frame_done", 32'(s_frame_done), 0);
    check("rst_rd_en", 32'(s_rd_en), 0);
    check("rst_d_busy", 32'(d_busy), 0);
    rst = 1'b0;

    s_write(8'd0, 1'b0);
    s_read(8'd0, 0, 1'b1);

    s_write(8'd0, 1'b0);
    s_read(8'd0, 1, 1'b0);

    s_write(8'd40, 1'b1);
    s_read(8'd40, 2, 1'b0);

    // reset after three writes, then a clean frame
    for (int i = 0; i < 3; i++) begin
      s_in_valid = 1'b1;
      s_in_data  = 8'(100 + i);
      @(posedge clk); #1;
    end
    s_in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    s_write(8'd10, 1'b0);
    s_read(8'd10, 0, 1'b1);

    // reset while READ has a full FIFO
    s_write(8'd20, 1'b0);
    s_out_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("s_full_valid", 32'(s_out_valid), 1);
    check("s_full_busy", 32'(s_busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("s_rst_read_valid", 32'(s_out_valid), 0);
    check("s_rst_read_busy", 32'(s_busy), 0);
    check("s_rst_read_ready", 32'(s_in_ready), 1);
    rst = 1'b0;
    s_write(8'd30, 1'b0);
    s_read(8'd30, 2, 1'b0);

    d_frame();
    d_frame();

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
